mul_sequencer: RTL and testbench

- Multi-cycle iterative multiplier with its own sequencing FSM. It serves MUL/MLA-class (32-bit result) and UMULL/SMULL-class (64-bit result) operations for the multicycle core.
- The core controller pulses `start` with operands read from the register file, holds in its multiply-wait state until `done`, then writes `result_lo` (and `result_hi` for long ops) back through the result path.
- Replaces a single-cycle combinational multiplier so the critical path is one adder of WIDTH+BPC bits.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/mul_step.sv | 27 ++
 rtl/mul_sequencer.sv | 149 ++++++++++++++
 tb/tb_mul_sequencer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
// Sequencer state encoding, iteration-count math and the BPC legality rule.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} mul_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BPC   = 1;

  function automatic int calc_n(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int calc_cnt_w(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

  function automatic bit bpc_legal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

  localparam int DEF_N      = calc_n(DEF_WIDTH, DEF_BPC);
  localparam int DEF_CNT_W  = calc_cnt_w(DEF_WIDTH, DEF_BPC);
  localparam bit DEF_BPC_OK = bpc_legal(DEF_WIDTH, DEF_BPC);

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/result bundle between the core controller (master) and the multiplier (slave).
interface mul_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             signed_op;
  logic             long_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, src_a, src_b, signed_op, long_op,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, src_a, src_b, signed_op, long_op,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: adds mcand * mbits into acc_hi, then shifts the pair right by BPC.
// The partial-product sum is WIDTH+BPC bits so no carry is lost before the shift.
module mul_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0]     acc_hi,
  input  logic [WIDTH-BPC-1:0] acc_lo_upper,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [BPC-1:0]       mbits,
  output logic [WIDTH-1:0]     acc_hi_next,
  output logic [WIDTH-1:0]     acc_lo_next
);
  localparam int SW = WIDTH + BPC;

  logic [SW-1:0] pp [BPC+1];

  assign pp[0] = {{BPC{1'b0}}, acc_hi};

  for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
    assign pp[gi+1] = pp[gi] + (mbits[gi] ? (SW'(mcand) << gi) : '0);
  end

  // Low BPC bits of the sum become finished product bits in acc_lo.
  assign acc_hi_next = pp[BPC][SW-1:BPC];
  assign acc_lo_next = {pp[BPC][BPC-1:0], acc_lo_upper};
endmodule

// File: rtl/mul_sequencer.sv
// Iterative WIDTH x WIDTH multiplier retiring BPC multiplier bits per cycle, with sign fix-up.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input logic          clk,
  input logic          reset,
  mul_sequencer_if.slave bus
);
  localparam int N      = calc_n(WIDTH, BPC);
  localparam int CNT_W  = calc_cnt_w(WIDTH, BPC);
  localparam bit BPC_OK = bpc_legal(WIDTH, BPC);

  if (!BPC_OK) begin : g_bpc_illegal
    $error("mul_sequencer: BPC must be 1, 2 or 4 and divide WIDTH");
  end

  mul_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic             sign_reg;
  logic             long_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] res_lo_reg;
  logic [WIDTH-1:0] res_hi_reg;
  logic             flag_n_reg;
  logic             flag_z_reg;

  logic [WIDTH-1:0]   acc_hi_next;
  logic [WIDTH-1:0]   acc_lo_next;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               sign_in;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;

  // Magnitudes: the most negative value maps to 2^(WIDTH-1), which fits unsigned.
  assign a_abs   = (bus.signed_op && bus.src_a[WIDTH-1]) ? (~bus.src_a + WIDTH'(1)) : bus.src_a;
  assign b_abs   = (bus.signed_op && bus.src_b[WIDTH-1]) ? (~bus.src_b + WIDTH'(1)) : bus.src_b;
  assign sign_in = bus.signed_op & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);

  assign prod_raw = {acc_hi_reg, acc_lo_reg};
  assign prod_fix = sign_reg ? (~prod_raw + (2*WIDTH)'(1)) : prod_raw;

  mul_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .acc_hi      (acc_hi_reg),
    .acc_lo_upper(acc_lo_reg[WIDTH-1:BPC]),
    .mcand       (mcand_reg),
    .mbits       (acc_lo_reg[BPC-1:0]),
    .acc_hi_next (acc_hi_next),
    .acc_lo_next (acc_lo_next)
  );

`ifdef MUL_EARLY_EXIT_EN
  localparam int SH_W = $clog2(2*WIDTH + 1);
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   rem_mask;
  logic               rem_zero;
  logic [2*WIDTH-1:0] prod_aligned;

  // The low cnt*BPC bits of acc_lo are multiplier bits not yet retired.
  assign shamt        = SH_W'(cnt_reg) * SH_W'(BPC);
  assign rem_mask     = ~({WIDTH{1'b1}} << shamt);
  assign rem_zero     = (acc_lo_reg & rem_mask) == '0;
  assign prod_aligned = prod_raw >> shamt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      sign_reg   <= 1'b0;
      long_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      res_lo_reg <= '0;
      res_hi_reg <= '0;
      flag_n_reg <= 1'b0;
      flag_z_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            mcand_reg  <= a_abs;
            acc_lo_reg <= b_abs;
            acc_hi_reg <= '0;
            sign_reg   <= sign_in;
            long_reg   <= bus.long_op;
            cnt_reg    <= CNT_W'(N);
            busy_reg   <= 1'b1;
            state_reg  <= ITER;
          end else begin
            state_reg  <= IDLE;
          end
        end
        ITER: begin
`ifdef MUL_EARLY_EXIT_EN
          if (rem_zero) begin
            {acc_hi_reg, acc_lo_reg} <= prod_aligned;
            cnt_reg   <= '0;
            state_reg <= FIX;
          end else begin
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            cnt_reg    <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) state_reg <= FIX;
          end
`else
          acc_hi_reg <= acc_hi_next;
          acc_lo_reg <= acc_lo_next;
          cnt_reg    <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_reg <= FIX;
`endif
        end
        FIX: begin
          res_lo_reg <= prod_fix[WIDTH-1:0];
          res_hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
          flag_n_reg <= long_reg ? prod_fix[2*WIDTH-1] : prod_fix[WIDTH-1];
          flag_z_reg <= long_reg ? (prod_fix == '0) : (prod_fix[WIDTH-1:0] == '0);
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
          state_reg  <= DONE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.result_lo = res_lo_reg;
  assign bus.result_hi = res_hi_reg;
  assign bus.flag_n    = flag_n_reg;
  assign bus.flag_z    = flag_z_reg;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed plus random checks of mul_sequencer against a 64-bit arithmetic reference.
// Latency expectations follow MUL_EARLY_EXIT_EN when it is defined for the build.
module tb_mul_sequencer;
  parameter int BPC = 1;
  localparam int WIDTH = 32;
  localparam int N = WIDTH / BPC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mul_sequencer #(.WIDTH(WIDTH), .BPC(BPC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Drive a request so that it is sampled on the next rising edge; returns #1 after that edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit l);
    bus.start = 1'b1; bus.src_a = a; bus.src_b = b; bus.signed_op = s; bus.long_op = l;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
    bus.signed_op = 1'($urandom); bus.long_op = 1'($urandom);
  endtask

  // Count edges from the accepting edge to done; optionally pulse a stray start at edge poke_at.
  task automatic wait_done(input int poke_at, output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = bus.busy ? 1 : 0;
    for (int i = 1; i <= 200; i++) begin
      if (i == poke_at) begin
        bus.start = 1'b1; bus.src_a = 32'hDEAD_BEEF; bus.src_b = 32'h0000_0003;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_cycles++;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit s, input bit l, input int lat, input int busy_cycles);
    logic [63:0] p;
    p = ref_prod(a, b, s);
    chk({tag, ".lo"}, 64'(bus.result_lo), 64'(p[31:0]));
    chk({tag, ".hi"}, 64'(bus.result_hi), 64'(p[63:32]));
    chk({tag, ".n"}, 64'(bus.flag_n), 64'(l ? p[63] : p[31]));
    chk({tag, ".z"}, 64'(bus.flag_z), 64'(l ? (p == 64'h0) : (p[31:0] == 32'h0)));
`ifdef MUL_EARLY_EXIT_EN
    chk({tag, ".lat_ok"}, 64'((lat >= 2) && (lat <= N + 1)), 64'(1));
    if (b == 32'h0) chk({tag, ".lat_zero"}, 64'(lat), 64'(2));
`else
    chk({tag, ".lat"}, 64'(lat), 64'(N + 1));
`endif
    chk({tag, ".busy_cycles"}, 64'(busy_cycles), 64'(lat));
    $display("op %s a=%08h b=%08h s=%0d l=%0d lat=%0d -> hi=%08h lo=%08h n=%0d z=%0d",
             tag, a, b, s, l, lat, bus.result_hi, bus.result_lo, bus.flag_n, bus.flag_z);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input bit l);
    int lat, bc;
    issue(a, b, s, l);
    wait_done(0, lat, bc);
    check_op(tag, a, b, s, l, lat, bc);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int lat, bc;
    logic [31:0] ra, rb;
    bit rs, rl;

    bus.start = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.signed_op = 1'b0; bus.long_op = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.done", 64'(bus.done), 64'(0));
    chk("rst.lo", 64'(bus.result_lo), 64'(0));
    chk("rst.hi", 64'(bus.result_hi), 64'(0));
    chk("rst.n", 64'(bus.flag_n), 64'(0));
    chk("rst.z", 64'(bus.flag_z), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("u7x6", 32'd7, 32'd6, 1'b0, 1'b0);
    run_op("umull_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("smull_m1x5", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
    run_op("smull_min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    run_op("zero_long", 32'h1234_5678, 32'h0, 1'b0, 1'b1);
    run_op("smul_neg_lo", 32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rl = 1'($urandom);
      if (t % 5 == 0) rb = 32'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", t), ra, rb, rs, rl);
    end

    // Stray start while busy must not disturb the running operation.
    issue(32'h0001_0003, 32'h8000_0001, 1'b0, 1'b1);
    wait_done((N >= 12) ? 9 : 2, lat, bc);
    check_op("ignore_start", 32'h0001_0003, 32'h8000_0001, 1'b0, 1'b1, lat, bc);
    @(posedge clk); #1;
    chk("ignore_start.no_requeue", 64'(bus.busy), 64'(0));

    // Back-to-back: start held in the DONE cycle.
    issue(32'h0000_1234, 32'h8765_4321, 1'b0, 1'b1);
    wait_done(0, lat, bc);
    check_op("b2b_first", 32'h0000_1234, 32'h8765_4321, 1'b0, 1'b1, lat, bc);
    issue(32'hFFFF_FF00, 32'h8000_0007, 1'b1, 1'b1);
    wait_done(0, lat, bc);
    check_op("b2b_second", 32'hFFFF_FF00, 32'h8000_0007, 1'b1, 1'b1, lat, bc);
    @(posedge clk); #1;

    // Reset in flight: outputs clear and the aborted op never reports done.
    issue(32'hCAFE_F00D, 32'h8000_0001, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.busy", 64'(bus.busy), 64'(0));
    chk("abort.done", 64'(bus.done), 64'(0));
    chk("abort.lo", 64'(bus.result_lo), 64'(0));
    chk("abort.hi", 64'(bus.result_hi), 64'(0));
    chk("abort.n", 64'(bus.flag_n), 64'(0));
    chk("abort.z", 64'(bus.flag_z), 64'(0));
    bc = 0;
    for (int i = 0; i < N + 5; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) bc++;
    end
    chk("abort.quiet", 64'(bc), 64'(0));
    $display("op abort_reset quiet_cycles_seen_active=%0d", bc);

    run_op("post_abort", 32'h0000_0009, 32'h0000_000B, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
